seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 8-digit 7-segment display.
//  - Takes the eight 8-bit segment patterns produced by the per-digit pattern converters.
//  - Drives one shared segment bus plus a one-hot digit select.
//  - Adds anti-ghost blanking, 8-level brightness, per-digit blink, and a tear-free update handshake.
//  - Sits between the pattern converters and the board LED pins.

---
 rtl/seg_scan_ctrl.sv | 115 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with anti-ghost blanking,
// 8-level brightness, per-digit blink and a frame-synchronous pattern update handshake.
module seg_scan_ctrl #(
   parameter int unsigned SCAN_DIV  = 64,
   parameter int unsigned BLANK_CYC = 4,
   parameter int unsigned STEP      = 4,
   parameter int unsigned BLINK_DIV = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [63:0] PAT_IN,
   input  logic        UPD_REQ,
   output logic        UPD_ACK,
   input  logic [2:0]  BRIGHT,
   input  logic [7:0]  BLINK_EN,
   output logic [7:0]  SEG_OUT,
   output logic [7:0]  DIG_SEL,
   output logic        FRAME_STB
);

   localparam int unsigned SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [7:0]  FRM_LAST  = 8'(BLINK_DIV - 1);
   localparam logic [7:0]  DASH      = 8'b00000010;

   logic [SW-1:0] slot_q, slot_d;
   logic [2:0]    dig_q, dig_d;
   logic [7:0]    frm_q, frm_d;
   logic          blink_q, blink_d;
   logic [63:0]   shadow_q, shadow_d;
   logic [7:0]    seg_q, seg_d;
   logic [7:0]    sel_q, sel_d;
   logic          ack_q, ack_d;
   logic          stb_q, stb_d;

   logic          frame_end;
   logic [31:0]   slot_w;
   logic [31:0]   lit_end;
   logic          in_win;
   logic          blanked;

   always_comb begin
      frame_end = (dig_q == 3'd7) && (slot_q == SLOT_LAST);

      slot_d  = slot_q + SW'(1);
      dig_d   = dig_q;
      frm_d   = frm_q;
      blink_d = blink_q;
      if (slot_q == SLOT_LAST) begin
         slot_d = '0;
         dig_d  = dig_q + 3'd1;
      end
      if (frame_end) begin
         if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            blink_d = ~blink_q;
         end else begin
            frm_d = frm_q + 8'd1;
         end
      end

      // Shadow only moves at frame end, so a frame never mixes old and new patterns.
      shadow_d = shadow_q;
      ack_d    = 1'b0;
      if (frame_end && UPD_REQ) begin
         shadow_d = PAT_IN;
         ack_d    = 1'b1;
      end
      stb_d = frame_end;
   end

   always_comb begin
      slot_w  = 32'(slot_q);
      lit_end = BLANK_CYC + (32'(BRIGHT) + 32'd1) * STEP;
      in_win  = (slot_w >= BLANK_CYC) && (slot_w < lit_end);
      blanked = blink_q && BLINK_EN[dig_q];

      sel_d = '0;
      seg_d = '0;
      if (in_win && !blanked) begin
         sel_d = 8'b1 << dig_q;
         seg_d = shadow_q[{dig_q, 3'b000} +: 8];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         slot_q   <= '0;
         dig_q    <= '0;
         frm_q    <= '0;
         blink_q  <= 1'b0;
         shadow_q <= {8{DASH}};
         seg_q    <= '0;
         sel_q    <= '0;
         ack_q    <= 1'b0;
         stb_q    <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         dig_q    <= dig_d;
         frm_q    <= frm_d;
         blink_q  <= blink_d;
         shadow_q <= shadow_d;
         seg_q    <= seg_d;
         sel_q    <= sel_d;
         ack_q    <= ack_d;
         stb_q    <= stb_d;
      end
   end

   assign SEG_OUT   = seg_q;
   assign DIG_SEL   = sel_q;
   assign UPD_ACK   = ack_q;
   assign FRAME_STB = stb_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at SCAN_DIV=16, BLANK_CYC=2, STEP=1, BLINK_DIV=2:
// 16-cycle slots, 128-cycle frames, blink phase flips every 2 frames.
module tb_seg_scan_ctrl;

   logic        CLK;
   logic        RST;
   logic [63:0] PAT_IN;
   logic        UPD_REQ;
   logic        UPD_ACK;
   logic [2:0]  BRIGHT;
   logic [7:0]  BLINK_EN;
   logic [7:0]  SEG_OUT;
   logic [7:0]  DIG_SEL;
   logic        FRAME_STB;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [63:0] exp_sh;

   localparam logic [63:0] DASHES = {8{8'h02}};

   seg_scan_ctrl #(.SCAN_DIV(16), .BLANK_CYC(2), .STEP(1), .BLINK_DIV(2)) dut (
      .CLK(CLK), .RST(RST), .PAT_IN(PAT_IN), .UPD_REQ(UPD_REQ), .UPD_ACK(UPD_ACK),
      .BRIGHT(BRIGHT), .BLINK_EN(BLINK_EN), .SEG_OUT(SEG_OUT), .DIG_SEL(DIG_SEL),
      .FRAME_STB(FRAME_STB)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Expected digit select for the state at cycle t (cycles counted from reset release).
   function automatic logic [7:0] f_dig(int t, logic [2:0] b, logic [7:0] en);
      int slot  = t % 16;
      int dg    = (t / 16) % 8;
      int frame = t / 128;
      bit ph    = ((frame / 2) % 2) == 1;
      if (slot >= 2 && slot < 3 + int'(b) && !(ph && en[dg])) return 8'b1 << dg;
      return 8'h00;
   endfunction

   function automatic logic [7:0] f_seg(int t, logic [2:0] b, logic [7:0] en, logic [63:0] sh);
      int dg = (t / 16) % 8;
      if (f_dig(t, b, en) != 8'h00) return sh[dg*8 +: 8];
      return 8'h00;
   endfunction

   task automatic tick(output int t);
      @(posedge CLK);
      #1;
      t = cyc;
      cyc++;
   endtask

   task automatic test_reset;
      int t;
      RST = 1'b1;
      tick(t);
      checks++; if (DIG_SEL !== 8'h00)  begin errors++; $display("FAIL reset_dig got %h want 00", DIG_SEL); end
      checks++; if (SEG_OUT !== 8'h00)  begin errors++; $display("FAIL reset_seg got %h want 00", SEG_OUT); end
      checks++; if (UPD_ACK !== 1'b0)   begin errors++; $display("FAIL reset_ack got %b want 0", UPD_ACK); end
      checks++; if (FRAME_STB !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", FRAME_STB); end
      RST    = 1'b0;
      cyc    = 0;
      exp_sh = DASHES;
   endtask

   task automatic test_idle;
      int t;
      logic [7:0] ed, es;
      BRIGHT = 3'd7; BLINK_EN = 8'h00; UPD_REQ = 1'b0;
      for (int i = 0; i < 256; i++) begin
         tick(t);
         ed = f_dig(t, BRIGHT, BLINK_EN);
         es = f_seg(t, BRIGHT, BLINK_EN, exp_sh);
         checks++; if (DIG_SEL !== ed) begin errors++; $display("FAIL idle_dig t=%0d got %h want %h", t, DIG_SEL, ed); end
         checks++; if (SEG_OUT !== es) begin errors++; $display("FAIL idle_seg t=%0d got %h want %h", t, SEG_OUT, es); end
         checks++; if (FRAME_STB !== (t % 128 == 127)) begin errors++; $display("FAIL idle_stb t=%0d got %b", t, FRAME_STB); end
         checks++; if (UPD_ACK !== 1'b0) begin errors++; $display("FAIL idle_ack t=%0d got %b want 0", t, UPD_ACK); end
      end
   endtask

   task automatic test_short_pulse;
      int t, s;
      logic [7:0] ed, es;
      PAT_IN = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 128; i++) begin
         s = cyc;
         UPD_REQ = (s % 128 >= 50) && (s % 128 < 55);
         tick(t);
         ed = f_dig(t, BRIGHT, BLINK_EN);
         es = f_seg(t, BRIGHT, BLINK_EN, exp_sh);
         checks++; if (DIG_SEL !== ed) begin errors++; $display("FAIL pulse_dig t=%0d got %h want %h", t, DIG_SEL, ed); end
         checks++; if (SEG_OUT !== es) begin errors++; $display("FAIL pulse_seg t=%0d got %h want %h", t, SEG_OUT, es); end
         checks++; if (UPD_ACK !== 1'b0) begin errors++; $display("FAIL pulse_ack t=%0d got %b want 0", t, UPD_ACK); end
      end
      UPD_REQ = 1'b0;
   endtask

   task automatic test_update;
      int t, s, acks;
      logic [7:0] ed, es;
      logic ea;
      acks = 0;
      PAT_IN = 64'hFCF260DAF266B6BE;
      for (int i = 0; i < 256; i++) begin
         s = cyc;
         if (s % 128 == 40 && acks == 0) UPD_REQ = 1'b1;
         tick(t);
         ed = f_dig(t, BRIGHT, BLINK_EN);
         es = f_seg(t, BRIGHT, BLINK_EN, exp_sh);
         ea = UPD_REQ && (t % 128 == 127);
         checks++; if (DIG_SEL !== ed) begin errors++; $display("FAIL upd_dig t=%0d got %h want %h", t, DIG_SEL, ed); end
         checks++; if (SEG_OUT !== es) begin errors++; $display("FAIL upd_seg t=%0d got %h want %h", t, SEG_OUT, es); end
         checks++; if (UPD_ACK !== ea) begin errors++; $display("FAIL upd_ack t=%0d got %b want %b", t, UPD_ACK, ea); end
         if (UPD_ACK === 1'b1) acks++;
         if (ea) begin
            exp_sh  = PAT_IN;
            UPD_REQ = 1'b0;
         end
      end
      checks++; if (acks != 1) begin errors++; $display("FAIL upd_ack_count got %0d want 1", acks); end
   endtask

   task automatic test_back_to_back;
      int t, acks;
      logic [7:0] ed, es;
      logic ea;
      acks = 0;
      PAT_IN  = 64'h0102040810204080;
      UPD_REQ = 1'b1;
      for (int i = 0; i < 256; i++) begin
         tick(t);
         ed = f_dig(t, BRIGHT, BLINK_EN);
         es = f_seg(t, BRIGHT, BLINK_EN, exp_sh);
         ea = UPD_REQ && (t % 128 == 127);
         checks++; if (DIG_SEL !== ed) begin errors++; $display("FAIL b2b_dig t=%0d got %h want %h", t, DIG_SEL, ed); end
         checks++; if (SEG_OUT !== es) begin errors++; $display("FAIL b2b_seg t=%0d got %h want %h", t, SEG_OUT, es); end
         checks++; if (UPD_ACK !== ea) begin errors++; $display("FAIL b2b_ack t=%0d got %b want %b", t, UPD_ACK, ea); end
         if (UPD_ACK === 1'b1) acks++;
         if (ea) exp_sh = PAT_IN;
      end
      UPD_REQ = 1'b0;
      checks++; if (acks != 2) begin errors++; $display("FAIL b2b_ack_count got %0d want 2", acks); end
   endtask

   task automatic test_bright;
      int t;
      logic [7:0] ed, es;
      for (int i = 0; i < 256; i++) begin
         BRIGHT = (i < 131) ? 3'd0 : 3'd3;
         tick(t);
         ed = f_dig(t, BRIGHT, BLINK_EN);
         es = f_seg(t, BRIGHT, BLINK_EN, exp_sh);
         checks++; if (DIG_SEL !== ed) begin errors++; $display("FAIL bright_dig t=%0d got %h want %h", t, DIG_SEL, ed); end
         checks++; if (SEG_OUT !== es) begin errors++; $display("FAIL bright_seg t=%0d got %h want %h", t, SEG_OUT, es); end
      end
   endtask

   task automatic test_blink;
      int t;
      logic [7:0] ed, es;
      BRIGHT = 3'd7; BLINK_EN = 8'h81;
      for (int i = 0; i < 512; i++) begin
         tick(t);
         ed = f_dig(t, BRIGHT, BLINK_EN);
         es = f_seg(t, BRIGHT, BLINK_EN, exp_sh);
         checks++; if (DIG_SEL !== ed) begin errors++; $display("FAIL blink_dig t=%0d got %h want %h", t, DIG_SEL, ed); end
         checks++; if (SEG_OUT !== es) begin errors++; $display("FAIL blink_seg t=%0d got %h want %h", t, SEG_OUT, es); end
         checks++; if (FRAME_STB !== (t % 128 == 127)) begin errors++; $display("FAIL blink_stb t=%0d got %b", t, FRAME_STB); end
      end
      BLINK_EN = 8'h00;
   endtask

   task automatic test_reset_mid;
      int t, s, acks;
      logic [7:0] ed, es;
      logic ea;
      BRIGHT = 3'd7; BLINK_EN = 8'h00;
      PAT_IN  = 64'hAAAA_AAAA_AAAA_AAAA;
      UPD_REQ = 1'b1;
      for (int i = 0; i < 128 && (cyc % 128) != 69; i++) tick(t);
      RST = 1'b1;
      tick(t);
      checks++; if (DIG_SEL !== 8'h00)  begin errors++; $display("FAIL rstmid_dig got %h want 00", DIG_SEL); end
      checks++; if (SEG_OUT !== 8'h00)  begin errors++; $display("FAIL rstmid_seg got %h want 00", SEG_OUT); end
      checks++; if (UPD_ACK !== 1'b0)   begin errors++; $display("FAIL rstmid_ack got %b want 0", UPD_ACK); end
      checks++; if (FRAME_STB !== 1'b0) begin errors++; $display("FAIL rstmid_stb got %b want 0", FRAME_STB); end
      RST = 1'b0; UPD_REQ = 1'b0; cyc = 0; exp_sh = DASHES;
      acks = 0;
      for (int i = 0; i < 256; i++) begin
         s = cyc;
         if (s == 128 + 10) UPD_REQ = 1'b1;
         tick(t);
         ed = f_dig(t, BRIGHT, BLINK_EN);
         es = f_seg(t, BRIGHT, BLINK_EN, exp_sh);
         ea = UPD_REQ && (t % 128 == 127);
         checks++; if (DIG_SEL !== ed) begin errors++; $display("FAIL rstmid_dig t=%0d got %h want %h", t, DIG_SEL, ed); end
         checks++; if (SEG_OUT !== es) begin errors++; $display("FAIL rstmid_seg t=%0d got %h want %h", t, SEG_OUT, es); end
         checks++; if (UPD_ACK !== ea) begin errors++; $display("FAIL rstmid_ack t=%0d got %b want %b", t, UPD_ACK, ea); end
         if (UPD_ACK === 1'b1) acks++;
         if (ea) begin
            exp_sh  = PAT_IN;
            UPD_REQ = 1'b0;
         end
      end
      checks++; if (acks != 1) begin errors++; $display("FAIL rstmid_ack_count got %0d want 1", acks); end
   endtask

   initial begin
      RST = 1'b1; UPD_REQ = 1'b0; PAT_IN = '0; BRIGHT = 3'd7; BLINK_EN = 8'h00;
      exp_sh = DASHES;
      test_reset;
      test_idle;
      test_short_pulse;
      test_update;
      test_back_to_back;
      test_bright;
      test_blink;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
